hazard_control_unit: RTL and testbench



---
 rtl/hazard_control_unit_pkg.sv | 21 ++
 rtl/hazard_control_unit_div_occupancy_ctr.sv | 62 ++++++
 rtl/hazard_control_unit.sv | 99 +++++++++
 tb/tb_hazard_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the hazard control unit: writeback select codes,
// RV32 opcode constants and the divider occupancy state type.
package hazard_control_unit_pkg;

  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_PC4  = 2'd1;
  localparam logic [1:0] SEL_CSR  = 2'd2;
  localparam logic [1:0] SEL_LOAD = 2'd3;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/hazard_control_unit_div_occupancy_ctr.sv
// Tracks how long a divide has occupied EXE; requests the EXE hold while it
// runs and flags the single cycle in which its result is valid.
module div_occupancy_ctr
  import hazard_control_unit_pkg::*;
#(
  parameter int DIV_LATENCY = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic exe_is_div,
  output logic div_stall,
  output logic div_done
);

  localparam int CNT_W = $clog2(DIV_LATENCY);
  // The entry cycle is spent in IDLE, so the countdown starts two short.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LATENCY - 2);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (exe_is_div) begin
          state_d = DIV_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      DIV_BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    div_stall = ((state_q == IDLE) && exe_is_div) ||
                ((state_q == DIV_BUSY) && (cnt_q != '0));
    div_done  = (state_q == DIV_BUSY) && (cnt_q == '0);
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush controller: resolves branch flushes, divide occupancy,
// the load-to-JALR interlock and ID jumps into per-stage hold/bubble controls.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int DIV_LATENCY = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rsA,
  input  logic       id_is_jalr,
  input  logic       id_jump,
  input  logic [4:0] exe_rd,
  input  logic       exe_wr_en,
  input  logic [1:0] exe_sel_data,
  input  logic       exe_is_div,
  input  logic       exe_branch_taken,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_exe,
  output logic       flush_id,
  output logic       flush_exe,
  output logic       flush_mem,
  output logic       fw_load_to_jalr,
  output logic       div_done
);

  logic div_stall;
  logic div_done_raw;
  logic load_jalr_hz;
  logic jalr_wait_q, jalr_wait_d;

  div_occupancy_ctr #(
    .DIV_LATENCY(DIV_LATENCY)
  ) u_div_occupancy_ctr (
    .clk       (clk),
    .rst       (rst),
    .exe_is_div(exe_is_div),
    .div_stall (div_stall),
    .div_done  (div_done_raw)
  );

  // Once waiting, the JALR is not re-flagged, bounding the interlock to one cycle.
  always_comb begin
    load_jalr_hz = id_is_jalr && exe_wr_en && (exe_sel_data == SEL_LOAD) &&
                   (exe_rd != 5'd0) && (exe_rd == id_rsA) && !jalr_wait_q;
  end

  always_comb begin
    jalr_wait_d = 1'b0;
    if (exe_branch_taken) begin
      jalr_wait_d = 1'b0;
    end else if (div_stall) begin
      jalr_wait_d = jalr_wait_q;
    end else if (load_jalr_hz) begin
      jalr_wait_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jalr_wait_q <= 1'b0;
    end else begin
      jalr_wait_q <= jalr_wait_d;
    end
  end

  // Outputs are forced low while reset is asserted, even though inputs may toggle.
  always_comb begin
    stall_if        = 1'b0;
    stall_id        = 1'b0;
    stall_exe       = 1'b0;
    flush_id        = 1'b0;
    flush_exe       = 1'b0;
    flush_mem       = 1'b0;
    fw_load_to_jalr = 1'b0;
    div_done        = 1'b0;
    if (!rst) begin
      fw_load_to_jalr = jalr_wait_q;
      div_done        = div_done_raw;
      if (exe_branch_taken) begin
        flush_id  = 1'b1;
        flush_exe = 1'b1;
      end else if (div_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_exe = 1'b1;
        flush_mem = 1'b1;
      end else if (load_jalr_hz) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        flush_exe = 1'b1;
      end else if (id_jump) begin
        flush_id = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-index reference model.
module tb_hazard_control_unit;

  localparam int L = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rsA;
  logic       id_is_jalr;
  logic       id_jump;
  logic [4:0] exe_rd;
  logic       exe_wr_en;
  logic [1:0] exe_sel_data;
  logic       exe_is_div;
  logic       exe_branch_taken;
  logic       stall_if, stall_id, stall_exe;
  logic       flush_id, flush_exe, flush_mem;
  logic       fw_load_to_jalr, div_done;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: index of the current divide within its EXE stay
  // during the previous cycle (0 = none), and whether a JALR forward is pending.
  int   divIdxPrev  = 0;
  logic fwdPending  = 1'b0;
  int   divIdxNext  = 0;
  logic fwdNext     = 1'b0;

  logic obsStall, obsDone;

  hazard_control_unit #(.DIV_LATENCY(L)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rsA          (id_rsA),
    .id_is_jalr      (id_is_jalr),
    .id_jump         (id_jump),
    .exe_rd          (exe_rd),
    .exe_wr_en       (exe_wr_en),
    .exe_sel_data    (exe_sel_data),
    .exe_is_div      (exe_is_div),
    .exe_branch_taken(exe_branch_taken),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_exe       (stall_exe),
    .flush_id        (flush_id),
    .flush_exe       (flush_exe),
    .flush_mem       (flush_mem),
    .fw_load_to_jalr (fw_load_to_jalr),
    .div_done        (div_done)
  );

  always #5 clk = ~clk;

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rsA, input logic jalr,
                               input logic jump, input logic [4:0] rd, input logic wr,
                               input logic [1:0] sel, input logic div, input logic br);
    rst              = r;
    id_rsA           = rsA;
    id_is_jalr       = jalr;
    id_jump          = jump;
    exe_rd           = rd;
    exe_wr_en        = wr;
    exe_sel_data     = sel;
    exe_is_div       = div;
    exe_branch_taken = br;
  endtask

  // Evaluates the model for the current cycle, compares all outputs, then
  // advances one clock and commits the model state.
  task automatic checkOutput(input string tag);
    int   cur;
    logic dStall, dDone, hz;
    logic eSif, eSid, eSexe, eFid, eFexe, eFmem, eFw, eDone;
    #2;
    cur = (divIdxPrev >= 1 && divIdxPrev < L) ? divIdxPrev + 1 : (exe_is_div ? 1 : 0);
    dStall = (cur >= 1) && (cur < L);
    dDone  = (cur == L);
    hz = id_is_jalr && exe_wr_en && (exe_sel_data == 2'd3) && (exe_rd != 0) &&
         (exe_rd == id_rsA) && !fwdPending;
    {eSif, eSid, eSexe, eFid, eFexe, eFmem, eFw, eDone} = '0;
    if (rst) begin
      divIdxNext = 0;
      fwdNext    = 1'b0;
    end else begin
      eFw   = fwdPending;
      eDone = dDone;
      if (exe_branch_taken) begin
        eFid = 1'b1; eFexe = 1'b1;
      end else if (dStall) begin
        eSif = 1'b1; eSid = 1'b1; eSexe = 1'b1; eFmem = 1'b1;
      end else if (hz) begin
        eSif = 1'b1; eSid = 1'b1; eFexe = 1'b1;
      end else if (id_jump) begin
        eFid = 1'b1;
      end
      divIdxNext = cur;
      fwdNext    = exe_branch_taken ? 1'b0 : (dStall ? fwdPending : hz);
    end
    checkBit({tag, ".stall_if"},  stall_if,        eSif);
    checkBit({tag, ".stall_id"},  stall_id,        eSid);
    checkBit({tag, ".stall_exe"}, stall_exe,       eSexe);
    checkBit({tag, ".flush_id"},  flush_id,        eFid);
    checkBit({tag, ".flush_exe"}, flush_exe,       eFexe);
    checkBit({tag, ".flush_mem"}, flush_mem,       eFmem);
    checkBit({tag, ".fw"},        fw_load_to_jalr, eFw);
    checkBit({tag, ".div_done"},  div_done,        eDone);
    obsStall = stall_if;
    obsDone  = div_done;
    @(posedge clk);
    #1;
    divIdxPrev = divIdxNext;
    fwdPending = fwdNext;
  endtask

  initial begin
    int stallCnt, doneCnt, doneAt;
    logic savedFw;

    // Reset with every input active: outputs must all be low.
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'd3, 1'b1, 1'b1);
    #1;
    checkOutput("reset_a");
    checkOutput("reset_b");
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("idle");

    // Two back-to-back divides with exe_is_div held throughout.
    for (int d = 0; d < 2; d++) begin
      stallCnt = 0; doneCnt = 0; doneAt = 0;
      for (int c = 1; c <= L; c++) begin
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput($sformatf("div%0d_c%0d", d, c));
        if (obsStall) stallCnt++;
        if (obsDone) begin doneCnt++; doneAt = c; end
      end
      checkBit($sformatf("div%0d_stall16", d), stallCnt == L - 1, 1'b1);
      checkBit($sformatf("div%0d_done_once", d), doneCnt == 1, 1'b1);
      checkBit($sformatf("div%0d_done_last", d), doneAt == L, 1'b1);
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("post_div");

    // LW x5 in EXE, JALR x5 in ID: one stall, then forward from memory.
    applyStimulus(1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("ldjalr_c0");
    checkBit("ldjalr_c0_stall", obsStall, 1'b1);
    applyStimulus(1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'd3, 1'b0, 1'b0);
    #2;
    savedFw = fw_load_to_jalr;
    checkBit("ldjalr_c1_fw", savedFw, 1'b1);
    checkOutput("ldjalr_c1");
    checkBit("ldjalr_c1_nostall", obsStall, 1'b0);

    // x0 destination and non-load writeback never interlock.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'd3, 1'b0, 1'b0);
    checkOutput("x0_no_hz");
    checkBit("x0_no_stall", obsStall, 1'b0);
    applyStimulus(1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0, 1'b0);
    checkOutput("alu_no_hz");
    checkBit("alu_no_stall", obsStall, 1'b0);

    // Taken branch overrides a simultaneous load->JALR hazard.
    applyStimulus(1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 2'd3, 1'b0, 1'b1);
    checkOutput("br_over_hz");
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("br_no_wait");

    // Reset asserted in divide cycle 5 aborts the divide.
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      checkOutput($sformatf("abort_c%0d", c));
    end
    applyStimulus(1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0);
    checkOutput("abort_rst");
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkOutput("abort_idle");
    checkBit("abort_no_done", obsDone, 1'b0);
    stallCnt = 0; doneAt = 0;
    for (int c = 1; c <= L; c++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0);
      checkOutput($sformatf("fresh_c%0d", c));
      if (obsStall) stallCnt++;
      if (obsDone) doneAt = c;
    end
    checkBit("fresh_stall16", stallCnt == L - 1, 1'b1);
    checkBit("fresh_done_last", doneAt == L, 1'b1);

    // Randomized traffic with small register space to provoke matches.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 3) == 0),
                    5'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 7) == 0));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
